// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, halt encoding, fetch states and word typedefs
// used by instruction_fetch, decode and the instruction ROM.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 9;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam addr_t  RESET_PC   = '0;
    localparam instr_t HALT_INSTR = 9'b1111_1_1111;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE   = 2'd0;
    localparam fetch_state_t FETCH_RUN    = 2'd1;
    localparam fetch_state_t FETCH_HALTED = 2'd2;

endpackage

// File: rtl/program_counter.sv
// program_counter: fetch PC register with branch load, wrapping increment and hold.
//   clk, reset : clock, asynchronous active-high reset (pc <= RESET_PC)
//   load       : take target this edge (wins over advance)
//   target     : redirect address
//   advance    : step to pc + 1, wrapping at 2^ADDR_W
//   pc         : current program counter
module program_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else if (load)
            pc <= target;
        else if (advance)
            pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the instruction ROM and decode.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : pulse, IDLE/HALTED -> RUN
//   rom_address     : combinational PC to the zero-wait ROM
//   rom_instruction : ROM word for rom_address
//   instr_out/instr_pc/instr_valid, instr_ready : one-entry output slot to decode
//   branch_en, branch_target : one-cycle redirect, flushes the slot
//   running, halted : state flags
module instruction_fetch #(
    parameter int                 ADDR_W     = cpu_pkg::ADDR_W,
    parameter int                 INSTR_W    = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [INSTR_W-1:0] rom_instruction,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               running,
    output logic               halted
);

    import cpu_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              fetch;
    logic              halt_hit;

    // A branch cycle never captures, so the redirect target is what the ROM
    // sees on the following edge (one bubble).
    assign fetch       = (state == FETCH_RUN) && (!instr_valid || instr_ready) && !branch_en;
    assign halt_hit    = fetch && (rom_instruction == HALT_INSTR);
    assign rom_address = pc;
    assign running     = (state == FETCH_RUN);
    assign halted      = (state == FETCH_HALTED);

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load    (branch_en),
        .target  (branch_target),
        .advance (fetch),
        .pc      (pc)
    );

    // Branches leave the state alone, so start and branch in the same cycle
    // both take effect. halt_hit implies RUN, so it never races start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH_IDLE;
        else if (halt_hit)
            state <= FETCH_HALTED;
        else if (start && state != FETCH_RUN)
            state <= FETCH_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else if (branch_en) begin
            instr_valid <= 1'b0;
        end else if (fetch) begin
            instr_valid <= 1'b1;
            instr_out   <= rom_instruction;
            instr_pc    <= pc;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized traffic against a reference model.
module tb_instruction_fetch;

    localparam logic [8:0] HALT = 9'b1111_1_1111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rom_address;
    logic [8:0] rom_instruction;
    logic [8:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       branch_en = 1'b0;
    logic [7:0] branch_target = '0;
    logic       running;
    logic       halted;

    logic [8:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 run, 2 halted.
    int         m_state;
    int         m_pc;
    bit         m_valid;
    logic [8:0] m_out;
    int         m_ipc;

    assign rom_instruction = rom[rom_address];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .branch_en       (branch_en),
        .branch_target   (branch_target),
        .running         (running),
        .halted          (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_valid = 0;
        m_out   = '0;
        m_ipc   = 0;
    endtask

    task automatic model_edge(input bit s, input bit r, input bit b, input int t);
        int  old  = m_state;
        bit  take = (old == 1) && (!m_valid || r) && !b;
        if (b) begin
            m_valid = 0;
            m_pc    = t;
        end else if (take) begin
            m_out   = rom[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) % 256;
        end else if (r) begin
            m_valid = 0;
        end
        if (take && m_out == HALT)
            m_state = 2;
        else if (s && old != 1)
            m_state = 1;
    endtask

    task automatic compare_all();
        check("rom_address", 32'(rom_address), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr_pc", 32'(instr_pc), 32'(m_ipc));
        check("instr_out", 32'(instr_out), 32'(m_out));
        check("running", 32'(running), 32'(m_state == 1));
        check("halted", 32'(halted), 32'(m_state == 2));
    endtask

    task automatic cyc(input bit s, input bit r, input bit b, input logic [7:0] t);
        @(negedge clk);
        start         = s;
        instr_ready   = r;
        branch_en     = b;
        branch_target = t;
        @(posedge clk);
        model_edge(s, r, b, int'(t));
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        start     = 1'b0;
        branch_en = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 9'($urandom);
            if (rom[i] == HALT) rom[i] = rom[i] ^ 9'h1;
        end
        rom[6] = HALT;
        model_reset();
        #7;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        cyc(1, 1, 0, 0);
        check("start_running", 32'(running), 1);
        check("start_no_valid", 32'(instr_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            check("seq_pc", 32'(instr_pc), 32'(i));
            check("seq_word", 32'(instr_out), 32'(rom[i]));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check("stall_pc", 32'(instr_pc), 2);
            check("stall_addr", 32'(rom_address), 3);
        end
        for (int i = 3; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            check("release_pc", 32'(instr_pc), 32'(i));
        end
        cyc(0, 0, 1, 8'h40);
        check("flush_valid", 32'(instr_valid), 0);
        cyc(0, 1, 0, 0);
        check("br_pc0", 32'(instr_pc), 32'h40);
        cyc(0, 1, 0, 0);
        check("br_pc1", 32'(instr_pc), 32'h41);
        cyc(0, 1, 1, 8'h06);
        cyc(0, 1, 0, 0);
        check("halt_pc", 32'(instr_pc), 6);
        check("halt_word", 32'(instr_out), 32'(HALT));
        check("halt_flag", 32'(halted), 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("halted_no_fetch", 32'(instr_valid), 0);
        check("halted_addr", 32'(rom_address), 7);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("resume_pc", 32'(instr_pc), 7);
        cyc(0, 1, 1, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0);
            check("wrap_pc", 32'(instr_pc), 32'((254 + i) % 256));
        end
        cyc(0, 0, 0, 0);
        check("pre_reset_valid", 32'(instr_valid), 1);
        async_reset();
        check("rst_addr", 32'(rom_address), 0);
        cyc(0, 1, 0, 0);
        check("rst_idle", 32'(instr_valid), 0);
        cyc(1, 1, 1, 8'h20);
        cyc(0, 1, 0, 0);
        check("start_branch_pc", 32'(instr_pc), 32'h20);

        for (int i = 0; i < 256; i++)
            if ($urandom_range(0, 15) == 0) rom[i] = HALT;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0)
                async_reset();
            else
                cyc($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the instruction ROM address and delivers 9-bit instructions to decode. Holds the program counter, registers each ROM word with its PC into a one-entry output slot under a valid/ready handshake, redirects on branches with a one-slot flush, and stops fetching when a halt word is fetched. Sits between the instruction ROM and the decode stage.

## Interface
- ADDR_W, 8, PC / ROM address width
- INSTR_W, 9, instruction width
- RESET_PC, 0, PC value after reset
- HALT_INSTR, 9'b1111_1_1111, encoding that stops fetch
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  one-cycle pulse: IDLE/HALTED -> RUN
- rom_address  output  ADDR_W  combinational copy of PC, to ROM
- rom_instruction  input  INSTR_W  combinational ROM data for rom_address
- instr_out  output  INSTR_W  registered instruction
- instr_pc  output  ADDR_W  PC the instr_out word was fetched from
- instr_valid  output  1  output slot holds an instruction
- instr_ready  input  1  decode accepts the slot this cycle
- branch_en  input  1  redirect request, one cycle
- branch_target  input  ADDR_W  redirect PC
- running  output  1  state == RUN
- halted  output  1  state == HALTED

## Operation
- States: IDLE (after reset), RUN, HALTED.
- IDLE --start--> RUN; RUN --halt word captured--> HALTED; HALTED --start--> RUN with PC unchanged (the word after the halt); start in RUN ignored.
- Fetch condition: state == RUN and (!instr_valid or instr_ready) and !branch_en.
- On fetch: instr_out <= rom_instruction, instr_pc <= pc, instr_valid <= 1, pc <= pc + 1 modulo 2^ADDR_W (255 -> 0, no flag).
- Consume without fetch (instr_valid and instr_ready, fetch condition false): instr_valid <= 0.
- Branch (any state): pc <= branch_target, instr_valid <= 0 (slot flushed whether or not instr_ready), no capture that cycle; state unchanged. Branch has priority over fetch and over the halt check.
- Halt: if the word captured equals HALT_INSTR, state -> HALTED in the same edge; the halt word is still delivered in the slot with instr_valid = 1 and held until consumed. No further fetches in HALTED.
- Slot holds instr_out/instr_pc stable while instr_valid and !instr_ready.
- Reset: pc = RESET_PC, state = IDLE, instr_valid = 0, instr_out = 0, instr_pc = 0, running = 0, halted = 0; rom_address = RESET_PC.

## Timing
- rom_address is combinational from pc; ROM data sampled at the same edge (zero-wait ROM).
- Latency: start at edge N -> RUN at N; first capture at edge N+1; instr_valid high after N+1.
- Throughput: one instruction per cycle while instr_ready held high.
- Branch at edge B: instr_valid low after B; word at branch_target valid after B+1 (one bubble).
- Back-pressure: instr_ready low -> pc and slot frozen; no ROM word dropped or duplicated.
- Reset asserted mid-operation: all state cleared asynchronously; pending slot discarded; fetch resumes only after a new start.
- Simultaneous start and branch in IDLE: both take effect; first fetch from branch_target at the next edge.

## Structure
- Shared package cpu_pkg: ADDR_W, INSTR_W, HALT_INSTR constants, fetch state enum (IDLE, RUN, HALTED), instr_t / addr_t typedefs; reused by decode and the ROM.
- One sub-module: program_counter (pc register, increment-with-wrap, load on branch, hold on stall). State machine and output slot stay in instruction_fetch.

## Test plan
- Reset then start, ROM words at 0..3, instr_ready = 1 -> instr_pc 0,1,2,3 on consecutive cycles, instr_out matches ROM, running = 1.
- instr_ready low for 3 cycles with slot holding pc 2 -> instr_out/instr_pc frozen, rom_address stays 3; on release pc 3 delivered next cycle, nothing skipped.
- branch_en with branch_target = 0x40 while slot holds pc 5 and instr_ready = 0 -> slot flushed next cycle, then instr_pc = 0x40, 0x41.
- HALT_INSTR at address 6 -> pc 6 delivered with instr_out = 9'b1111_1_1111, halted = 1, no further fetches; start -> fetch resumes at pc 7.
- branch_target = 0xFE, run freely -> instr_pc 0xFE, 0xFF, 0x00, 0x01.
- reset asserted mid-stream with instr_valid = 1 -> instr_valid, running, halted drop immediately, rom_address = 0, state IDLE until start.
